error_epc_unit: RTL and testbench



---
 rtl/error_epc_unit.sv | 61 ++++++
 tb/tb_error_epc_unit.sv | 136 +++++++++++++
 2 files changed

// File: rtl/error_epc_unit.sv
// CP0 ErrorEPC register: captures the restart PC on reset-class/cache-error exceptions, MTC0 writable, gated MFC0 read.
// Optional: ERROR_EPC_WORD_ALIGN_EN forces software writes to a word-aligned value.
module error_epc_unit #(
  parameter int                 DATA_W    = 32,
  parameter logic [DATA_W-1:0]  RESET_VAL = '0,
  parameter int                 BD_OFFSET = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              r_p,
  input  logic              r_h,
  input  logic              cache_err,
  input  logic              we_s,
  input  logic              bd_p,
  input  logic [DATA_W-1:0] pc_p,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] read_data
);

  localparam logic [DATA_W-1:0] BD_OFF = DATA_W'(BD_OFFSET);

  logic [DATA_W-1:0] epc_q;
  logic [DATA_W-1:0] epc_d;
  logic              cap;

  // Delay-slot faults restart at the branch, so step back one instruction (wraps modulo 2^DATA_W).
  function automatic logic [DATA_W-1:0] restart_pc(input logic [DATA_W-1:0] pc,
                                                   input logic              bd);
    return bd ? (pc - BD_OFF) : pc;
  endfunction

  function automatic logic [DATA_W-1:0] sw_value(input logic [DATA_W-1:0] wd);
`ifdef ERROR_EPC_WORD_ALIGN_EN
    return {wd[DATA_W-1:2], 2'b00};
`else
    return wd;
`endif
  endfunction

  assign cap = r_h | cache_err;

  always_comb begin
    epc_d = epc_q;
    if (cap) begin
      epc_d = restart_pc(pc_p, bd_p);
    end else if (we_s) begin
      epc_d = sw_value(write_data);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      epc_q <= RESET_VAL;
    end else begin
      epc_q <= epc_d;
    end
  end

  assign read_data = r_p ? epc_q : '0;

endmodule

// File: tb/tb_error_epc_unit.sv
// Bench for error_epc_unit: directed vector table, async-reset sequence, and randomized cycles against a reference model.
module tb_error_epc_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        r_p, r_h, cache_err, we_s, bd_p;
  logic [31:0] pc_p, write_data, read_data;

  int checks = 0;
  int errors = 0;
  logic [31:0] model_epc;

  error_epc_unit #(.DATA_W(32), .RESET_VAL(32'h0), .BD_OFFSET(4)) dut (
    .clk(clk), .rst(rst), .r_p(r_p), .r_h(r_h), .cache_err(cache_err),
    .we_s(we_s), .bd_p(bd_p), .pc_p(pc_p), .write_data(write_data),
    .read_data(read_data)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  typedef struct packed {
    logic        rh, ce, we, bd;
    logic [31:0] pc, wd;
    logic        rp;
    logic [31:0] exp_epc;
  } vec_t;

  function automatic logic [31:0] sw_stored(input logic [31:0] wd);
`ifdef ERROR_EPC_WORD_ALIGN_EN
    return wd & 32'hFFFF_FFFC;
`else
    return wd;
`endif
  endfunction

  // Reference: exceptions win, a delay-slot PC steps back 4 bytes mod 2^32, otherwise writes, otherwise hold.
  function automatic logic [31:0] ref_next(input logic [31:0] cur, input logic rh, ce, we, bd,
                                           input logic [31:0] pc, wd);
    longint unsigned v;
    if (rh || ce) begin
      v = bd ? (longint'(pc) + 64'h1_0000_0000 - 4) % 64'h1_0000_0000 : longint'(pc);
      return v[31:0];
    end
    if (we) return sw_stored(wd);
    return cur;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: read_data=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic apply(input logic rh, ce, we, bd, input logic [31:0] pc, wd,
                       input logic rp, input logic [31:0] exp_epc, input string name);
    @(negedge clk);
    r_h = rh; cache_err = ce; we_s = we; bd_p = bd; pc_p = pc; write_data = wd; r_p = rp;
    #1;
    check({name, "_pre"}, read_data, rp ? model_epc : 32'h0);
    @(posedge clk);
    #1;
    model_epc = exp_epc;
    check(name, read_data, rp ? model_epc : 32'h0);
  endtask

  vec_t vecs [10];

  initial begin
    vecs[0] = '{rh:1, ce:1, we:0, bd:0, pc:32'h4,      wd:32'h0,         rp:1, exp_epc:32'h4};
    vecs[1] = '{rh:1, ce:0, we:0, bd:1, pc:32'h4,      wd:32'h0,         rp:1, exp_epc:32'h0};
    vecs[2] = '{rh:1, ce:0, we:0, bd:1, pc:32'h0,      wd:32'h0,         rp:1, exp_epc:32'hFFFF_FFFC};
    vecs[3] = '{rh:0, ce:0, we:1, bd:0, pc:32'h0,      wd:32'hF,         rp:1, exp_epc:sw_stored(32'hF)};
    vecs[4] = '{rh:1, ce:0, we:1, bd:0, pc:32'h100,    wd:32'hAA,        rp:1, exp_epc:32'h100};
    vecs[5] = '{rh:0, ce:0, we:0, bd:1, pc:32'h55,     wd:32'h77,        rp:0, exp_epc:32'h100};
    vecs[6] = '{rh:0, ce:0, we:0, bd:0, pc:32'h0,      wd:32'h0,         rp:1, exp_epc:32'h100};
    vecs[7] = '{rh:0, ce:1, we:0, bd:1, pc:32'h2000,   wd:32'h0,         rp:1, exp_epc:32'h1FFC};
    vecs[8] = '{rh:0, ce:0, we:1, bd:1, pc:32'h1234,   wd:32'hDEAD_BEEF, rp:1, exp_epc:sw_stored(32'hDEAD_BEEF)};
    vecs[9] = '{rh:0, ce:1, we:1, bd:1, pc:32'h8000_0000, wd:32'h5,      rp:1, exp_epc:32'h7FFF_FFFC};

    rst = 1'b0; r_p = 1'b1; r_h = 1'b0; cache_err = 1'b0; we_s = 1'b0; bd_p = 1'b0;
    pc_p = '0; write_data = '0;
    model_epc = 32'h0;
    #12;
    check("reset_read", read_data, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 10; i++) begin
      apply(vecs[i].rh, vecs[i].ce, vecs[i].we, vecs[i].bd, vecs[i].pc, vecs[i].wd,
            vecs[i].rp, vecs[i].exp_epc, $sformatf("vec%0d", i));
    end

    // Async reset mid-cycle with a capture pending: clears before the next edge.
    apply(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h1234_5670, 1'b1, sw_stored(32'h1234_5670), "pre_rst_write");
    @(negedge clk);
    r_h = 1'b1; pc_p = 32'hCAFE_0000; r_p = 1'b1; we_s = 1'b0;
    #1;
    rst = 1'b0;
    #1;
    check("async_rst_immediate", read_data, 32'h0);
    @(posedge clk);
    #1;
    check("rst_overrides_capture", read_data, 32'h0);
    r_h = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    model_epc = 32'h0;
    apply(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0, "hold_after_rst");

    for (int i = 0; i < 400; i++) begin
      logic rh, ce, we, bd, rp;
      logic [31:0] pc, wd;
      rh = ($urandom_range(0, 5) == 0);
      ce = ($urandom_range(0, 5) == 0);
      we = $urandom_range(0, 1);
      bd = $urandom_range(0, 1);
      rp = ($urandom_range(0, 3) != 0);
      pc = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 7) : $urandom;
      wd = $urandom;
      apply(rh, ce, we, bd, pc, wd, rp, ref_next(model_epc, rh, ce, we, bd, pc, wd),
            $sformatf("rand%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
